bw_io_misc_bsr_ctl: RTL and testbench
=====================================

BW_IO_MISC_BSR_CTL -- requirements
Module: bw_io_misc_bsr_ctl

Interface
REQ-001 Parameter: CHAIN_LEN, default 6, boundary-scan cells in the misc pad chain.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  command offered.
REQ-005 req_ready  out  1  controller idle; a command is accepted on an edge where req_valid and req_ready are both 1.
REQ-006 req_op  in  2  00 SCAN, 01 SHIFT, 10 SET_MODE, 11 reserved.
REQ-007 req_len  in  3  shift length minus one; L = req_len+1, range 1..8.
REQ-008 req_wdata  in  8  serial data, LSB shifted first; SET_MODE uses bit0=mode_ctl and bit1=hiz_l.
REQ-009 rsp_valid  out  1  response held until it is taken.
REQ-010 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both 1.
REQ-011 rsp_rdata  out  8  captured bso bits, right-aligned.
REQ-012 rsp_err  out  1  reserved op.
REQ-013 shift_dr, clock_dr, update_dr  out  1 each  BSR controls to the pad chain.
REQ-014 mode_ctl, hiz_l  out  1 each  static pad-test controls.
REQ-015 bsi  out  1  serial input to the first chain cell.
REQ-016 bso  in  1  serial output of the last chain cell.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States SHALL be IDLE, CAP_SU, CAP_PU, BIT_SU, BIT_PU, UPD_SU, UPD_PU and DONE.
REQ-019 The controller SHALL assert req_ready only in IDLE.
REQ-020 SCAN SHALL follow the sequence IDLE->CAP_SU->CAP_PU->(BIT_SU->BIT_PU)xL->UPD_SU->UPD_PU->DONE.
REQ-021 SHIFT SHALL follow the sequence IDLE->(BIT_SU->BIT_PU)xL->DONE, with no capture and no update.
REQ-022 SET_MODE SHALL load mode_ctl and hiz_l from req_wdata[1:0] on the accepting edge and go to DONE.
REQ-023 A reserved op SHALL go to DONE with rsp_err=1 and no pin activity.
REQ-024 Each _SU cycle SHALL drive clock_dr=0 and update_dr=0; CAP_PU and BIT_PU SHALL drive clock_dr=1; UPD_PU SHALL drive update_dr=1; clock_dr and update_dr are never 1 together.
REQ-025 shift_dr SHALL be 1 exactly in BIT_SU and BIT_PU, and 0 in CAP_* and UPD_*.
REQ-026 In bit i (i=0..L-1), bsi SHALL equal wdata[i] through both BIT_SU and BIT_PU.
REQ-027 In bit i, bso SHALL be sampled in BIT_SU into rdata[i].
REQ-028 rdata[7:L] SHALL be 0.
REQ-029 Latency: counting the accepting edge as edge 1, rsp_valid SHALL rise after edge 2L+5 for SCAN, 2L+1 for SHIFT, and 1 for SET_MODE/reserved.
REQ-030 DONE SHALL hold rsp_valid, rsp_rdata and rsp_err stable until the handshake edge, then return to IDLE (req_ready=1 on the next cycle).
REQ-031 rsp_valid and req_ready are never both 1.
REQ-032 The command SHALL be latched at acceptance; req_* changes while busy SHALL be ignored.
REQ-033 SCAN and SHIFT SHALL leave mode_ctl and hiz_l unchanged.
REQ-034 A 4-bit down-counter SHALL track the remaining bits.
REQ-035 Bit counting SHALL NOT wrap: the last BIT_PU exits when the count reaches 0.

Reset
REQ-036 Reset SHALL force: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, shift_dr=0, clock_dr=0, update_dr=0, bsi=0, mode_ctl=0, hiz_l=1.
REQ-037 Reset mid-operation SHALL abandon the command with no further clock_dr or update_dr pulse and no response.
REQ-038 Reset SHALL take priority over a simultaneous req_valid.

Structure
REQ-039 A shared package SHALL hold the op enum, state enum, CHAIN_LEN default and op encodings.
REQ-040 The block SHALL be one module; the bit counter and the rdata shifter are inline (no sub-module).

Verification
REQ-041 Out of reset: req_ready=1, hiz_l=1, mode_ctl=0 and all pulse outputs 0; SET_MODE wdata=0x01 -> mode_ctl=1, hiz_l=0, rsp_valid after 1 edge.
REQ-042 SCAN L=6, wdata=0x2D, 6-cell loopback model: 6 bsi bits 1,0,1,1,0,1; rdata = model capture value; exactly 1 update_dr pulse; rsp after 17 edges.
REQ-043 SHIFT L=8, wdata=0xA5, bso tied 1 -> 8 clock_dr pulses, 0 update_dr pulses, rdata=0xFF, rsp after 17 edges.
REQ-044 rsp_ready held 0 for 10 cycles -> rsp_valid and rdata stable, req_ready=0; after release, req_ready=1 on the next cycle.
REQ-045 reset asserted in the 3rd BIT_PU of a SCAN -> outputs at reset values on the next cycle; no update_dr; no rsp_valid afterwards.
REQ-046 Reserved op 11 -> rsp_err=1 after 1 edge; shift_dr, clock_dr and update_dr never toggle.

Source files
------------

// File: rtl/bw_io_misc_bsr_ctl_pkg.sv
// Shared types and encodings for the misc-pad boundary-scan register controller.
// Holds the command opcodes, the sequencer state set and the default chain length.
package bw_io_misc_bsr_ctl_pkg;

    localparam int unsigned CHAIN_LEN_DEFAULT = 6;

    localparam logic [1:0] OP_SCAN_ENC     = 2'b00;
    localparam logic [1:0] OP_SHIFT_ENC    = 2'b01;
    localparam logic [1:0] OP_SET_MODE_ENC = 2'b10;
    localparam logic [1:0] OP_RSVD_ENC     = 2'b11;

    typedef enum logic [1:0] {
        OP_SCAN     = OP_SCAN_ENC,
        OP_SHIFT    = OP_SHIFT_ENC,
        OP_SET_MODE = OP_SET_MODE_ENC,
        OP_RSVD     = OP_RSVD_ENC
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAP_SU,
        S_CAP_PU,
        S_BIT_SU,
        S_BIT_PU,
        S_UPD_SU,
        S_UPD_PU,
        S_DONE
    } state_e;

endpackage

// File: rtl/bw_io_misc_bsr_ctl.sv
// Command-driven sequencer for the misc pad boundary-scan chain: capture, shift and
// update phases with setup/pulse cycle pairs, plus static pad-test mode controls.
module bw_io_misc_bsr_ctl
    import bw_io_misc_bsr_ctl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [2:0] req_len,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       shift_dr,
    output logic       clock_dr,
    output logic       update_dr,
    output logic       mode_ctl,
    output logic       hiz_l,
    output logic       bsi,
    input  logic       bso
);

    // The chain length only documents the attached pad chain; a zero-length chain is illegal.
    if (CHAIN_LEN < 1) begin : g_chain_len_invalid
    end

    state_e     state, state_n;
    op_e        op_q, op_n;
    logic [2:0] len_q, len_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] wd_sh, wd_n;
    logic [7:0] rdata_n;
    logic       err_n, mode_n, hiz_n;
    logic       ready_n, valid_n, shift_n, clk_n, upd_n, bsi_n;
    logic [2:0] bit_idx;

    // Bit i is in flight while cnt = L - i remaining bits are outstanding.
    assign bit_idx = len_q - 3'(cnt - 4'd1);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
        state_n = state;
        op_n    = op_q;
        len_n   = len_q;
        cnt_n   = cnt;
        wd_n    = wd_sh;
        rdata_n = rsp_rdata;
        err_n   = rsp_err;
        mode_n  = mode_ctl;
        hiz_n   = hiz_l;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_n    = op_e'(req_op);
                    len_n   = req_len;
                    cnt_n   = {1'b0, req_len} + 4'd1;
                    wd_n    = req_wdata;
                    rdata_n = '0;
                    err_n   = 1'b0;
                    case (op_e'(req_op))
                        OP_SCAN:  state_n = S_CAP_SU;
                        OP_SHIFT: state_n = S_BIT_SU;
                        OP_SET_MODE: begin
                            mode_n  = req_wdata[0];
                            hiz_n   = req_wdata[1];
                            state_n = S_DONE;
                        end
                        default: begin
                            err_n   = 1'b1;
                            state_n = S_DONE;
                        end
                    endcase
                end
            end
            S_CAP_SU: state_n = S_CAP_PU;
            S_CAP_PU: state_n = S_BIT_SU;
            S_BIT_SU: begin
                rdata_n[bit_idx] = bso;
                state_n          = S_BIT_PU;
            end
            S_BIT_PU: begin
                cnt_n = cnt - 4'd1;
                wd_n  = {1'b0, wd_sh[7:1]};
                if (cnt_n == 4'd0) begin
                    state_n = (op_q == OP_SCAN) ? S_UPD_SU : S_DONE;
                end else begin
                    state_n = S_BIT_SU;
                end
            end
            S_UPD_SU: state_n = S_UPD_PU;
            S_UPD_PU: state_n = S_DONE;
            S_DONE: begin
                if (rsp_valid && rsp_ready) begin
                    err_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Pin values are decoded from the state being entered so they register alongside it.
        ready_n = (state_n == S_IDLE);
        valid_n = (state_n == S_DONE);
        shift_n = (state_n == S_BIT_SU) || (state_n == S_BIT_PU);
        clk_n   = (state_n == S_CAP_PU) || (state_n == S_BIT_PU);
        upd_n   = (state_n == S_UPD_PU);
        bsi_n   = shift_n & wd_n[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_SCAN;
            len_q     <= '0;
            cnt       <= '0;
            wd_sh     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            shift_dr  <= 1'b0;
            clock_dr  <= 1'b0;
            update_dr <= 1'b0;
            bsi       <= 1'b0;
            mode_ctl  <= 1'b0;
            hiz_l     <= 1'b1;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state     <= state_n;
            op_q      <= op_n;
            len_q     <= len_n;
            cnt       <= cnt_n;
            wd_sh     <= wd_n;
            req_ready <= ready_n;
            rsp_valid <= valid_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            shift_dr  <= shift_n;
            clock_dr  <= clk_n;
            update_dr <= upd_n;
            bsi       <= bsi_n;
            mode_ctl  <= mode_n;
            hiz_l     <= hiz_n;
        end
    end

endmodule

// File: tb/tb_bw_io_misc_bsr_ctl.sv
// Bench for bw_io_misc_bsr_ctl: drives a 6-cell loopback chain and checks every
// command against a bit-level chain model, pin-activity counters and latency rules.
module tb_bw_io_misc_bsr_ctl;
    import bw_io_misc_bsr_ctl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [2:0] req_len = 3'd0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       shift_dr, clock_dr, update_dr;
    logic       mode_ctl, hiz_l, bsi, bso;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bw_io_misc_bsr_ctl #(.CHAIN_LEN(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .shift_dr  (shift_dr),
        .clock_dr  (clock_dr),
        .update_dr (update_dr),
        .mode_ctl  (mode_ctl),
        .hiz_l     (hiz_l),
        .bsi       (bsi),
        .bso       (bso)
    );

    // Pad chain: cell 0 fed by bsi, cell 5 drives bso; capture loads the pad values.
    logic [5:0] chain   = 6'h00;
    logic [5:0] pad_val = 6'h00;
    logic       tie_one = 1'b0;
    assign bso = tie_one ? 1'b1 : chain[5];

    always @(posedge clk) begin
        if (clock_dr) chain <= shift_dr ? {chain[4:0], bsi} : pad_val;
    end

    // Pin activity observed mid-cycle.
    int   n_clk_hi = 0, n_upd_hi = 0, n_shift_hi = 0, n_rspv_hi = 0, n_bad = 0;
    logic bsi_pu_log[$];
    logic bsi_su_log[$];

    always @(negedge clk) begin
        if (clock_dr)  n_clk_hi++;
        if (update_dr) n_upd_hi++;
        if (shift_dr)  n_shift_hi++;
        if (rsp_valid) n_rspv_hi++;
        if (clock_dr && update_dr) n_bad++;
        if (rsp_valid && req_ready) n_bad++;
        if (shift_dr && clock_dr)  bsi_pu_log.push_back(bsi);
        if (shift_dr && !clock_dr) bsi_su_log.push_back(bsi);
    end

    // Reference model state.
    logic [5:0] m_chain = 6'h00;
    logic       m_mode  = 1'b0;
    logic       m_hiz   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] len, input logic [7:0] wd,
                           input int hold, input logic tie);
        int         L;
        int         lat, c0, u0, s0, p0, q0;
        int         exp_lat, exp_clk, exp_upd, exp_bits;
        logic [7:0] exp_rd, exp_w, obs_pu, obs_su;
        logic       exp_err;

        L        = int'(len) + 1;
        exp_rd   = 8'h00;
        exp_w    = 8'h00;
        exp_err  = (op == OP_RSVD_ENC);
        exp_lat  = 1;
        exp_clk  = 0;
        exp_upd  = 0;
        exp_bits = 0;
        if (op == OP_SCAN_ENC || op == OP_SHIFT_ENC) begin
            if (op == OP_SCAN_ENC) begin
                m_chain = pad_val;
                exp_lat = 2 * L + 5;
                exp_clk = L + 1;
                exp_upd = 1;
            end else begin
                exp_lat = 2 * L + 1;
                exp_clk = L;
            end
            exp_bits = L;
            for (int i = 0; i < L; i++) begin
                exp_rd[i] = tie ? 1'b1 : m_chain[5];
                exp_w[i]  = wd[i];
                m_chain   = {m_chain[4:0], wd[i]};
            end
        end else if (op == OP_SET_MODE_ENC) begin
            m_mode = wd[0];
            m_hiz  = wd[1];
        end

        @(negedge clk);
        chk("req_ready_before_cmd", req_ready, 1);
        tie_one   = tie;
        req_valid = 1'b1;
        req_op    = op;
        req_len   = len;
        req_wdata = wd;
        @(posedge clk);
        #1;
        c0 = n_clk_hi;
        u0 = n_upd_hi;
        s0 = n_shift_hi;
        p0 = bsi_pu_log.size();
        q0 = bsi_su_log.size();
        req_valid = $urandom_range(0, 1);
        req_op    = 2'($urandom);
        req_len   = 3'($urandom);
        req_wdata = 8'($urandom);

        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;

        obs_pu = 8'h00;
        obs_su = 8'h00;
        for (int i = 0; i < L; i++) begin
            if (p0 + i < bsi_pu_log.size()) obs_pu[i] = bsi_pu_log[p0 + i];
            if (q0 + i < bsi_su_log.size()) obs_su[i] = bsi_su_log[q0 + i];
        end

        chk("latency",          lat, exp_lat);
        chk("rsp_rdata",        rsp_rdata, exp_rd);
        chk("rsp_err",          rsp_err, exp_err);
        chk("req_ready_busy",   req_ready, 0);
        chk("clock_dr_pulses",  n_clk_hi - c0, exp_clk);
        chk("update_dr_pulses", n_upd_hi - u0, exp_upd);
        chk("shift_dr_cycles",  n_shift_hi - s0, 2 * exp_bits);
        chk("bsi_pu_count",     bsi_pu_log.size() - p0, exp_bits);
        chk("bsi_in_bit_pu",    obs_pu, exp_w);
        chk("bsi_in_bit_su",    obs_su, exp_w);
        chk("mode_ctl",         mode_ctl, m_mode);
        chk("hiz_l",            hiz_l, m_hiz);

        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, exp_rd);
            chk("hold_req_ready", req_ready, 0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        tie_one   = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rsp", req_ready, 1);
        chk("rsp_valid_after_rsp", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         c0, u0, v0;
        logic [1:0] op;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {req_ready, rsp_valid, rsp_rdata, rsp_err, shift_dr, clock_dr, update_dr, bsi, mode_ctl, hiz_l},
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        reset = 1'b0;

        // Mode load, then the directed chain scenarios.
        run_cmd(OP_SET_MODE_ENC, 3'd0, 8'h01, 0, 1'b0);
        pad_val = 6'b110010;
        run_cmd(OP_SCAN_ENC, 3'd5, 8'h2D, 0, 1'b0);
        run_cmd(OP_SHIFT_ENC, 3'd7, 8'hA5, 0, 1'b1);
        run_cmd(OP_SCAN_ENC, 3'd3, 8'h9C, 10, 1'b0);
        run_cmd(OP_RSVD_ENC, 3'd5, 8'hFF, 0, 1'b0);
        run_cmd(OP_SET_MODE_ENC, 3'd2, 8'h02, 0, 1'b0);

        // Randomised command mix.
        for (int n = 0; n < 16; n++) begin
            op      = 2'($urandom_range(0, 3));
            pad_val = 6'($urandom);
            run_cmd(op, 3'($urandom), 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        // Reset during the third BIT_PU of a SCAN.
        pad_val = 6'h2A;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SCAN_ENC;
        req_len   = 3'd7;
        req_wdata = 8'hC6;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("in_third_bit_pu", {shift_dr, clock_dr}, 2'b11);
        reset = 1'b1;
        @(posedge clk);
        #1;
        c0 = n_clk_hi;
        u0 = n_upd_hi;
        v0 = n_rspv_hi;
        @(negedge clk);
        chk("midop_reset_outputs",
            {req_ready, rsp_valid, rsp_rdata, rsp_err, shift_dr, clock_dr, update_dr, bsi, mode_ctl, hiz_l},
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abandon_clock_dr", n_clk_hi - c0, 0);
        chk("abandon_update_dr", n_upd_hi - u0, 0);
        chk("abandon_rsp_valid", n_rspv_hi - v0, 0);
        m_mode  = 1'b0;
        m_hiz   = 1'b1;
        m_chain = pad_val;
        for (int i = 0; i < 3; i++) m_chain = {m_chain[4:0], req_wdata[i]};

        // Reset wins over a simultaneous command.
        reset     = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_SET_MODE_ENC;
        req_wdata = 8'h01;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("reset_priority",
            {req_ready, rsp_valid, mode_ctl, hiz_l}, {1'b1, 1'b0, 1'b0, 1'b1});

        // Chain state after the abandoned scan still matches the model.
        run_cmd(OP_SHIFT_ENC, 3'd7, 8'h3B, 0, 1'b0);

        chk("pin_exclusivity_violations", n_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
